// File: rtl/serial_collector.sv
// Serial-to-parallel collector for a bit-serial adder: gathers WIDTH sum bits LSB first plus the carry.
// Define COLLECT_PARITY_EN to add a trailing even-parity bit per frame and the perr output.
module serial_collector #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_in,
  input  logic             c_in,
  input  logic             ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             valid,
  output logic             busy,
  output logic             overrun
`ifdef COLLECT_PARITY_EN
  ,
  output logic             perr
`endif
);

`ifdef COLLECT_PARITY_EN
  localparam int NBITS = WIDTH + 1;
  localparam int CW    = $clog2(WIDTH + 2);
`else
  localparam int NBITS = WIDTH;
  localparam int CW    = $clog2(WIDTH + 1);
`endif
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
`ifdef COLLECT_PARITY_EN
  logic             perr_pend_q, perr_pend_d;
  logic             perr_q, perr_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
`ifdef COLLECT_PARITY_EN
    perr_pend_d = perr_pend_q;
    perr_d      = perr_q;
`endif
    case (state_q)
      IDLE: if (start) cnt_d = '0;
      SHIFT: begin
        cnt_d = cnt_q + CW'(1);
`ifdef COLLECT_PARITY_EN
        // The trailing parity bit is checked, not shifted into the sum.
        if (cnt_q < CW'(WIDTH)) shreg_d = {s_in, shreg_q[WIDTH-1:1]};
        if (cnt_q == LAST) perr_pend_d = (^shreg_q) ^ s_in;
`else
        shreg_d = {s_in, shreg_q[WIDTH-1:1]};
`endif
        if (cnt_q == LAST) carry_d = c_in;
      end
      DONE: begin
        // Hand-off wins if the slot is free or is being emptied this same edge.
        if (!valid_q || ready) begin
          sum_d   = shreg_q;
          cout_d  = carry_q;
          valid_d = 1'b1;
`ifdef COLLECT_PARITY_EN
          perr_d  = perr_pend_q;
`endif
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (state_q != DONE && valid_q && ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      shreg_q     <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef COLLECT_PARITY_EN
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
`ifdef COLLECT_PARITY_EN
      perr_pend_q <= perr_pend_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign sum     = sum_q;
  assign cout    = cout_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
`ifdef COLLECT_PARITY_EN
  assign perr    = perr_q;
`endif

endmodule

// File: tb/tb_serial_collector.sv
// Directed bench for serial_collector: per-cycle comparison against a frame-level model plus literal checks.
// Define COLLECT_PARITY_EN for both files to exercise the parity variant.
module tb_serial_collector;

  localparam int WIDTH = 4;
`ifdef COLLECT_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             s_in = 1'b0;
  logic             c_in = 1'b0;
  logic             ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout, valid, busy, overrun;
`ifdef COLLECT_PARITY_EN
  logic             perr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  serial_collector #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .s_in   (s_in),
    .c_in   (c_in),
    .ready  (ready),
    .sum    (sum),
    .cout   (cout),
    .valid  (valid),
    .busy   (busy),
    .overrun(overrun)
`ifdef COLLECT_PARITY_EN
    ,
    .perr   (perr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Frame-level model: tracks bit position since start, accumulates the sum arithmetically.
  bit m_active = 0, m_pending = 0, m_was_idle;
  int m_idx = 0, m_acc = 0;
  bit m_carry = 0, m_par = 0;
  int m_sum = 0;
  bit m_cout = 0, m_valid = 0, m_overrun = 0, m_perr = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_pending = 0; m_idx = 0; m_acc = 0; m_carry = 0; m_par = 0;
      m_sum = 0; m_cout = 0; m_valid = 0; m_overrun = 0; m_perr = 0;
    end else begin
      m_was_idle = !m_active && !m_pending;
      if (m_pending) begin
        if (!m_valid || ready) begin
          m_sum   = m_acc;
          m_cout  = m_carry;
          m_perr  = (($countones(m_acc) + int'(m_par)) % 2) == 1;
          m_valid = 1;
        end else begin
          m_overrun = 1;
        end
        m_pending = 0;
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
      if (m_active) begin
        if (m_idx < WIDTH) m_acc = m_acc + (int'(s_in) << m_idx);
        else               m_par = s_in;
        if (m_idx == NB - 1) begin
          m_carry   = c_in;
          m_active  = 0;
          m_pending = 1;
        end
        m_idx++;
      end else if (m_was_idle && start) begin
        m_active = 1;
        m_idx    = 0;
        m_acc    = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("sum",     32'(sum),     32'(m_sum));
    check("cout",    32'(cout),    32'(m_cout));
    check("valid",   32'(valid),   32'(m_valid));
    check("busy",    32'(busy),    32'(m_active || m_pending));
    check("overrun", 32'(overrun), 32'(m_overrun));
`ifdef COLLECT_PARITY_EN
    check("perr",    32'(perr),    32'(m_perr));
`endif
  end

  // Inputs change 1 ns after the falling edge, clear of both sampling points.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Returns just after the edge that samples the last bit (edge k+NB).
  task automatic frame(input logic [WIDTH-1:0] bits, input logic carry, input logic par,
                       input bit mid_start);
    tick();
    start = 1'b1;
    for (int i = 0; i < NB; i++) begin
      tick();
      start = mid_start && (i == 1);
      s_in  = (i < WIDTH) ? bits[i] : par;
      c_in  = (i == NB - 1) ? carry : ~carry;
    end
    tick();
    start = 1'b0;
    s_in  = 1'b0;
    c_in  = 1'b0;
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #12 rst = 1'b0;

    // a) basic frame and latency
    frame(4'b1001, 1'b1, 1'b0, 1'b0);
    check("a_busy_done", 32'(busy), 32'd1);
    check("a_valid_lat", 32'(valid), 32'd0);
    tick();
    check("a_valid", 32'(valid), 32'd1);
    check("a_sum", 32'(sum), 32'h9);
    check("a_cout", 32'(cout), 32'd1);
    check("a_busy_idle", 32'(busy), 32'd0);

    // b) second frame while result is unaccepted is dropped
    frame(4'b0110, 1'b0, 1'b0, 1'b0);
    tick();
    check("b_sum_kept", 32'(sum), 32'h9);
    check("b_cout_kept", 32'(cout), 32'd1);
    check("b_overrun", 32'(overrun), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("b_valid_clr", 32'(valid), 32'd0);
    check("b_sum_after", 32'(sum), 32'h9);

    // c) ready in the DONE edge lets a new frame replace a held one
    pulse_reset();
    frame(4'b0110, 1'b1, 1'b0, 1'b0);
    tick();
    frame(4'b1111, 1'b0, 1'b0, 1'b0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("c_sum", 32'(sum), 32'hF);
    check("c_cout", 32'(cout), 32'd0);
    check("c_valid", 32'(valid), 32'd1);
    check("c_overrun", 32'(overrun), 32'd0);

    // d) abort after two bits, then a full frame with a stray start mid-shift
    pulse_reset();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    s_in  = 1'b1;
    tick();
    tick();
    rst  = 1'b1;
    s_in = 1'b0;
    tick();
    rst = 1'b0;
    check("d_sum_abort", 32'(sum), 32'h0);
    check("d_valid_abort", 32'(valid), 32'd0);
    check("d_busy_abort", 32'(busy), 32'd0);
    frame(4'b1010, 1'b1, 1'b0, 1'b1);
    check("d_valid_lat", 32'(valid), 32'd0);
    check("d_sum_lat", 32'(sum), 32'h0);
    tick();
    check("d_sum", 32'(sum), 32'hA);
    check("d_valid", 32'(valid), 32'd1);
    check("d_busy_idle", 32'(busy), 32'd0);

`ifdef COLLECT_PARITY_EN
    // e) parity good then bad; valid one edge later than without parity
    pulse_reset();
    frame(4'b1001, 1'b0, 1'b0, 1'b0);
    check("e_valid_lat", 32'(valid), 32'd0);
    tick();
    check("e_valid", 32'(valid), 32'd1);
    check("e_perr_ok", 32'(perr), 32'd0);
    ready = 1'b1;
    frame(4'b1001, 1'b0, 1'b1, 1'b0);
    tick();
    ready = 1'b0;
    check("e_perr_bad", 32'(perr), 32'd1);
    check("e_sum", 32'(sum), 32'h9);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
